// File: rtl/bus_grant_arbiter_if.sv
// rtl/bus_grant_arbiter_if.sv - request/grant bundle between cores, memory and the bus arbiter
//
// Purpose: carries the per-core request vector, the shared-bus memory Ready
// and the arbiter's grant outputs for one bus (instruction or data).
// Signals:
//   Bus_RQ         [N_MASTERS]  request vector, bit i is core i's RQ
//   Bus_Mem_Ready  [1]          memory Ready as seen on the shared bus
//   Bus_GRANT      [N_MASTERS]  registered one-hot grant
//   Grant_Valid    [1]          high while any grant bit is high
//   Grant_Id       [ID_W]       index of current (or last) owner
//   Timeout_Pulse  [1]          one-cycle pulse on a forced revoke
// Modports:
//   master  requester side (drives RQ and Ready, observes grant)
//   slave   arbiter side (observes RQ and Ready, drives grant)

interface bus_grant_arbiter_if #(
  parameter int N_MASTERS = 4,
  parameter int ID_W      = 2
);
  logic [N_MASTERS-1:0] Bus_RQ;
  logic                 Bus_Mem_Ready;
  logic [N_MASTERS-1:0] Bus_GRANT;
  logic                 Grant_Valid;
  logic [ID_W-1:0]      Grant_Id;
  logic                 Timeout_Pulse;

  modport master (
    output Bus_RQ, Bus_Mem_Ready,
    input  Bus_GRANT, Grant_Valid, Grant_Id, Timeout_Pulse
  );

  modport slave (
    input  Bus_RQ, Bus_Mem_Ready,
    output Bus_GRANT, Grant_Valid, Grant_Id, Timeout_Pulse
  );
endinterface

// File: rtl/bus_grant_arbiter.sv
// rtl/bus_grant_arbiter.sv - round-robin shared-bus arbiter with memory-Ready turnaround gap
//
// Purpose: grants the shared bus to one core at a time, round-robin from a
// rotating pointer. A grant is held until its owner drops RQ; the bus then
// sits idle until memory Ready has fallen before the next grant (RELEASE then
// IDLE, so at least two idle cycles between owners).
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    bus_grant_arbiter_if.slave (Bus_RQ, Bus_Mem_Ready in;
//          Bus_GRANT, Grant_Valid, Grant_Id, Timeout_Pulse out, all registered)
// Optional feature macro: BUS_ARB_TIMEOUT_EN
//   defined   - a grant held for MAX_HOLD cycles is revoked, Timeout_Pulse
//               fires, and the revoked core is masked until its RQ goes low
//   undefined - no hold counter, mask fixed at 0, Timeout_Pulse tied low

module bus_grant_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int ID_W      = 2,
  parameter int MAX_HOLD  = 64
) (
  input logic             clk,
  input logic             reset,
  bus_grant_arbiter_if.slave bus
);

  if (N_MASTERS < 2 || N_MASTERS > (1 << ID_W) || MAX_HOLD < 1) begin : g_bad_params
    $error("bus_grant_arbiter: illegal parameter combination");
  end

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic                 valid_q, valid_d;
  logic [ID_W-1:0]      id_q, id_d;

  logic [N_MASTERS-1:0] req_eff;
  logic                 sel_found;
  logic [ID_W-1:0]      sel_idx;
  logic [ID_W:0]        cand;
  logic [ID_W-1:0]      ptr_after_owner;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [N_MASTERS-1:0] mask_q, mask_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 tmo_q, tmo_d;
  logic                 hold_expired;

  // Counter starts at 0 on the grant edge, so reaching MAX_HOLD-1 while
  // still BUSY means the grant has been high for MAX_HOLD cycles.
  assign hold_expired = (hold_q == HOLD_W'(MAX_HOLD - 1));
  assign req_eff      = bus.Bus_RQ & ~mask_q;
  assign bus.Timeout_Pulse = tmo_q;
`else
  assign req_eff      = bus.Bus_RQ;
  assign bus.Timeout_Pulse = 1'b0;
`endif

  assign bus.Bus_GRANT   = grant_q;
  assign bus.Grant_Valid = valid_q;
  assign bus.Grant_Id    = id_q;

  assign ptr_after_owner = (id_q == ID_W'(N_MASTERS - 1)) ? '0 : id_q + 1'b1;

  // First eligible requester at or above the pointer, wrapping to 0.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(N_MASTERS)) begin
        cand = cand - (ID_W+1)'(N_MASTERS);
      end
      if (!sel_found && req_eff[cand[ID_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    valid_d = valid_q;
    id_d    = id_q;
`ifdef BUS_ARB_TIMEOUT_EN
    // A mask bit survives only while that core keeps RQ high.
    mask_d  = mask_q & bus.Bus_RQ;
    hold_d  = hold_q;
    tmo_d   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          valid_d          = 1'b1;
          id_d             = sel_idx;
          state_d          = ST_BUSY;
`ifdef BUS_ARB_TIMEOUT_EN
          hold_d           = '0;
`endif
        end
      end

      ST_BUSY: begin
        if (!bus.Bus_RQ[id_q]) begin
          grant_d = '0;
          valid_d = 1'b0;
          ptr_d   = ptr_after_owner;
          state_d = ST_RELEASE;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (hold_expired) begin
          grant_d      = '0;
          valid_d      = 1'b0;
          ptr_d        = ptr_after_owner;
          state_d      = ST_RELEASE;
          tmo_d        = 1'b1;
          mask_d[id_q] = 1'b1;
        end else if (hold_q != HOLD_W'(MAX_HOLD)) begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end

      ST_RELEASE: begin
        // Previous transaction is over only once memory has dropped Ready.
        if (!bus.Bus_Mem_Ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      mask_q  <= '0;
      hold_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      id_q    <= id_d;
`ifdef BUS_ARB_TIMEOUT_EN
      mask_q  <= mask_d;
      hold_q  <= hold_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// tb/tb_bus_grant_arbiter.sv - directed scoreboard bench for bus_grant_arbiter

module tb_bus_grant_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bus_grant_arbiter_if #(.N_MASTERS(4), .ID_W(2)) bus ();

  bus_grant_arbiter #(.N_MASTERS(4), .ID_W(2), .MAX_HOLD(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string      tag;
    logic [3:0] grant;
    logic       valid;
    logic [1:0] id;
    logic       tmo;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic compare_head();
    exp_t e;
    logic [7:0] got, want;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: got no entry, required one entry");
      return;
    end
    e    = sb.pop_front();
    got  = {bus.Bus_GRANT, bus.Grant_Valid, bus.Grant_Id, bus.Timeout_Pulse};
    want = {e.grant, e.valid, e.id, e.tmo};
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got grant=%b valid=%b id=%0d tmo=%b, required grant=%b valid=%b id=%0d tmo=%b",
             e.tag, bus.Bus_GRANT, bus.Grant_Valid, bus.Grant_Id, bus.Timeout_Pulse,
             e.grant, e.valid, e.id, e.tmo);
    end
  endtask

  // Drive inputs for the coming edge, queue what must appear after it,
  // then sample 1 time unit past that edge.
  task automatic cyc(input logic [3:0] rq, input logic rdy, input string tag,
                     input logic [3:0] g, input logic v, input logic [1:0] id,
                     input logic t = 1'b0);
    exp_t e;
    bus.Bus_RQ        = rq;
    bus.Bus_Mem_Ready = rdy;
    e = '{tag, g, v, id, t};
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  initial begin
    exp_t e;
    reset             = 1'b0;
    bus.Bus_RQ        = 4'b1111;
    bus.Bus_Mem_Ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with every core requesting
    cyc(4'b1111, 1'b0, "reset_hold0", 4'b0000, 1'b0, 2'd0);
    cyc(4'b1111, 1'b0, "reset_hold1", 4'b0000, 1'b0, 2'd0);
    reset = 1'b1;
    cyc(4'b1111, 1'b0, "reset_release_grant0", 4'b0001, 1'b1, 2'd0);

    // Round robin 0,1,2,3,0 with 3-cycle ownership and a 1-cycle RQ drop
    for (int k = 0; k < 4; k++) begin
      logic [3:0] own, nxt, drop_rq;
      logic [1:0] kid, nid;
      kid     = 2'(k);
      nid     = 2'((k + 1) % 4);
      own     = 4'b0001 << k;
      nxt     = 4'b0001 << ((k + 1) % 4);
      drop_rq = 4'b1111 & ~own;
      cyc(4'b1111, 1'b0, "rr_hold_a",  own,     1'b1, kid);
      cyc(4'b1111, 1'b0, "rr_hold_b",  own,     1'b1, kid);
      cyc(drop_rq, 1'b0, "rr_drop",    4'b0000, 1'b0, kid);
      cyc(4'b1111, 1'b0, "rr_release", 4'b0000, 1'b0, kid);
      cyc(4'b1111, 1'b0, "rr_next",    nxt,     1'b1, nid);
    end

    // Everyone drops, stays idle, then a lone request from core 2
    cyc(4'b0000, 1'b0, "all_drop",      4'b0000, 1'b0, 2'd0);
    cyc(4'b0000, 1'b0, "all_release",   4'b0000, 1'b0, 2'd0);
    cyc(4'b0000, 1'b0, "idle_stay",     4'b0000, 1'b0, 2'd0);
    cyc(4'b0100, 1'b0, "single_grant2", 4'b0100, 1'b1, 2'd2);
    cyc(4'b0100, 1'b0, "single_hold",   4'b0100, 1'b1, 2'd2);
    cyc(4'b0000, 1'b0, "single_drop",   4'b0000, 1'b0, 2'd2);
    cyc(4'b0100, 1'b0, "single_gap",    4'b0000, 1'b0, 2'd2);
    cyc(4'b0100, 1'b0, "single_regrant",4'b0100, 1'b1, 2'd2);

    // Move ownership to core 1
    cyc(4'b0010, 1'b1, "to1_drop2",     4'b0000, 1'b0, 2'd2);
    cyc(4'b0010, 1'b1, "to1_ready_wait",4'b0000, 1'b0, 2'd2);
    cyc(4'b0010, 1'b0, "to1_idle",      4'b0000, 1'b0, 2'd2);
    cyc(4'b0010, 1'b0, "to1_grant",     4'b0010, 1'b1, 2'd1);

    // Memory hold-off: Ready stays high for 5 cycles after owner 1 drops
    cyc(4'b1000, 1'b1, "holdoff_drop1", 4'b0000, 1'b0, 2'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1000, 1'b1, "holdoff_ready_high", 4'b0000, 1'b0, 2'd1);
    end
    cyc(4'b1000, 1'b0, "holdoff_ready_fell", 4'b0000, 1'b0, 2'd1);
    cyc(4'b1000, 1'b0, "holdoff_grant3",     4'b1000, 1'b1, 2'd3);

    // Park the pointer at 2 while core 1 owns the bus
    cyc(4'b0010, 1'b0, "park_drop3",   4'b0000, 1'b0, 2'd3);
    cyc(4'b0010, 1'b0, "park_idle_a",  4'b0000, 1'b0, 2'd3);
    cyc(4'b0010, 1'b0, "park_grant1a", 4'b0010, 1'b1, 2'd1);
    cyc(4'b0000, 1'b0, "park_drop1",   4'b0000, 1'b0, 2'd1);
    cyc(4'b0010, 1'b0, "park_idle_b",  4'b0000, 1'b0, 2'd1);
    cyc(4'b0010, 1'b0, "park_grant1b", 4'b0010, 1'b1, 2'd1);

    // Asynchronous reset between edges while core 1 holds the grant
    #3;
    reset = 1'b0;
    e = '{"midgrant_reset_async", 4'b0000, 1'b0, 2'd0, 1'b0};
    sb.push_back(e);
    #1;
    compare_head();
    #2;
    reset = 1'b1;
    // Pointer back at 0: cores 1 and 3 requesting, core 1 wins
    cyc(4'b1010, 1'b0, "after_reset_ptr0", 4'b0010, 1'b1, 2'd1);

`ifdef BUS_ARB_TIMEOUT_EN
    cyc(4'b0000, 1'b0, "tmo_drop1",   4'b0000, 1'b0, 2'd1);
    cyc(4'b0000, 1'b0, "tmo_idle",    4'b0000, 1'b0, 2'd1);
    cyc(4'b0001, 1'b0, "tmo_grant0",  4'b0001, 1'b1, 2'd0);
    for (int i = 0; i < 7; i++) begin
      cyc(4'b0101, 1'b0, "tmo_holding", 4'b0001, 1'b1, 2'd0);
    end
    cyc(4'b0101, 1'b0, "tmo_revoke",  4'b0000, 1'b0, 2'd0, 1'b1);
    cyc(4'b0101, 1'b0, "tmo_release", 4'b0000, 1'b0, 2'd0);
    cyc(4'b0101, 1'b0, "tmo_grant2",  4'b0100, 1'b1, 2'd2);
    cyc(4'b0001, 1'b0, "tmo_drop2",   4'b0000, 1'b0, 2'd2);
    cyc(4'b0001, 1'b0, "tmo_idle2",   4'b0000, 1'b0, 2'd2);
    cyc(4'b0001, 1'b0, "tmo_masked0", 4'b0000, 1'b0, 2'd2);
    cyc(4'b0000, 1'b0, "tmo_rq0_low", 4'b0000, 1'b0, 2'd2);
    cyc(4'b0001, 1'b0, "tmo_regrant0",4'b0001, 1'b1, 2'd0);
`endif

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
